// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: state encoding and byte-lane constants shared by the memory stage
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data bus between the memory stage (master) and memory (slave)
interface mem_access_stage_if #(parameter int WIDTH = 32);
  logic mem_req;
  logic mem_we;
  logic mem_ack;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [3:0] mem_be;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_stage_byte_lane.sv
// mem_byte_lane: byte enables, store-data replication and load-byte extraction
module mem_byte_lane
  import mem_stage_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             is_byte,
  input  logic [1:0]       lane,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic [WIDTH-1:0] rdata_in,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [7:0] sel;
  assign sel = lane == LANE3 ? rdata_in[31:24] :
               lane == LANE2 ? rdata_in[23:16] :
               lane == LANE1 ? rdata_in[15:8]  : rdata_in[7:0];
  assign be    = is_byte ? 4'b0001 << lane : BE_WORD;
  assign wdata = is_byte ? {(WIDTH/8){wdata_in[7:0]}} : wdata_in;
  assign rdata = is_byte ? {{(WIDTH-8){1'b0}}, sel} : rdata_in;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage issuing loads/stores on a req/ack bus, stalling upstream
// Optional MEM_TIMEOUT_EN: abort a BUSY access after TIMEOUT cycles and raise sticky mem_err.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             ByteM,
  input  logic [3:0]       WA3M,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             StallM,
  output logic             PCSrcO,
  output logic             RegWriteO,
  output logic             MemtoRegO,
  output logic [3:0]       WA3O,
  output logic [WIDTH-1:0] ALUOutO,
  output logic [WIDTH-1:0] ReadDataO,
  mem_access_stage_if.master bus
`ifdef MEM_TIMEOUT_EN
  , output logic           mem_err
`endif
);
  state_t state, state_n;
  logic access, ack_hit, expire, stall, pass;
  logic [3:0] lane_be;
  logic [WIDTH-1:0] lane_wdata, lane_rdata, rdata_q;
  assign access  = MemtoRegM | MemWriteM;
  assign ack_hit = state == BUSY && bus.mem_ack;
  mem_byte_lane #(.WIDTH(WIDTH)) u_lane (
    .is_byte (ByteM),
    .lane    (ALUOutM[1:0]),
    .wdata_in(WriteDataM),
    .rdata_in(bus.mem_rdata),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .rdata   (lane_rdata)
  );
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expire = state == BUSY && !bus.mem_ack && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt     <= state == BUSY ? cnt + 1'b1 : '0;
      mem_err <= mem_err | expire;
    end
  end
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n = IDLE;
    stall   = 1'b0;
    state_n = state == IDLE ? (access ? BUSY : IDLE) :
              state == BUSY ? ((ack_hit || expire) ? DONE : BUSY) : IDLE;
    stall   = state == BUSY || (state == IDLE && access);
  end
  // Bus fields are latched once on entry to BUSY so they stay stable until ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      rdata_q       <= '0;
    end else if (state == IDLE && access) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= MemWriteM;
      bus.mem_addr  <= {ALUOutM[WIDTH-1:2], 2'b00};
      bus.mem_wdata <= lane_wdata;
      bus.mem_be    <= lane_be;
      rdata_q       <= '0;
    end else if (ack_hit || expire) begin
      bus.mem_req   <= 1'b0;
      rdata_q       <= ack_hit ? lane_rdata : '0;
    end
  end
  assign pass      = reset && !stall;
  assign StallM    = reset && stall;
  assign PCSrcO    = pass && PCSrcM;
  assign RegWriteO = pass && RegWriteM;
  assign MemtoRegO = pass && MemtoRegM;
  assign WA3O      = reset ? WA3M : '0;
  assign ALUOutO   = reset ? ALUOutM : '0;
  assign ReadDataO = (reset && state == DONE) ? rdata_q : '0;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset;
  logic PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ByteM;
  logic [3:0] WA3M;
  logic [31:0] ALUOutM, WriteDataM;
  logic StallM, PCSrcO, RegWriteO, MemtoRegO;
  logic [3:0] WA3O;
  logic [31:0] ALUOutO, ReadDataO;
`ifdef MEM_TIMEOUT_EN
  logic mem_err;
`endif
  int n_checks = 0;
  int n_fail = 0;
  int stalls;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_be;
  logic s_we, s_req, s_bubble;
  always #5 clk = ~clk;
  mem_access_stage_if bus();
  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ByteM(ByteM), .WA3M(WA3M), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .StallM(StallM), .PCSrcO(PCSrcO), .RegWriteO(RegWriteO), .MemtoRegO(MemtoRegO),
    .WA3O(WA3O), .ALUOutO(ALUOutO), .ReadDataO(ReadDataO),
    .bus(bus)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic pcs, rw, m2r, mw, by, input logic [3:0] wa,
                       input logic [31:0] alu, wd);
    PCSrcM = pcs; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw; ByteM = by;
    WA3M = wa; ALUOutM = alu; WriteDataM = wd;
  endtask
  // Runs one access from its IDLE cycle until StallM falls; ack pulses in stall cycle ack_at.
  task automatic run_op(input int ack_at, input logic [31:0] rdata, output int n_stall,
                        output logic [31:0] addr, output logic [3:0] be,
                        output logic [31:0] wdata, output logic we, req, bubble);
    n_stall = 0; addr = '0; be = '0; wdata = '0; we = 1'b0; req = 1'b0; bubble = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      bus.mem_ack = (k == ack_at);
      bus.mem_rdata = rdata;
      #1;
      if (k == 0) bubble = PCSrcO | RegWriteO | MemtoRegO;
      if (k == 1) begin
        req = bus.mem_req; addr = bus.mem_addr; be = bus.mem_be;
        wdata = bus.mem_wdata; we = bus.mem_we;
      end
      if (!StallM) break;
      n_stall++;
    end
    bus.mem_ack = 1'b0;
    check("op_completes", {31'b0, StallM}, 32'd0);
  endtask
  task automatic go_idle();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0);
    #1;
  endtask
  initial begin
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    drive(1, 1, 0, 0, 0, 4'd5, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, StallM}, 32'd0);
    check("rst_regwrite", {31'b0, RegWriteO}, 32'd0);
    check("rst_pcsrc", {31'b0, PCSrcO}, 32'd0);
    check("rst_wa3", {28'b0, WA3O}, 32'd0);
    check("rst_aluout", ALUOutO, 32'd0);
    check("rst_rdata", ReadDataO, 32'd0);
    check("rst_req", {31'b0, bus.mem_req}, 32'd0);
`ifdef MEM_TIMEOUT_EN
    check("rst_err", {31'b0, mem_err}, 32'd0);
`endif
    reset = 1'b1;
    #1;
    check("pt_regwrite", {31'b0, RegWriteO}, 32'd1);
    check("pt_pcsrc", {31'b0, PCSrcO}, 32'd1);
    check("pt_memtoreg", {31'b0, MemtoRegO}, 32'd0);
    check("pt_wa3", {28'b0, WA3O}, 32'd5);
    check("pt_aluout", ALUOutO, 32'h10);
    check("pt_stall", {31'b0, StallM}, 32'd0);
    check("pt_rdata", ReadDataO, 32'd0);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 4'd3, 32'h20, 32'h0);
    run_op(2, 32'hDEADBEEF, stalls, s_addr, s_be, s_wdata, s_we, s_req, s_bubble);
    check("wl_stalls", stalls, 32'd3);
    check("wl_bubble", {31'b0, s_bubble}, 32'd0);
    check("wl_req", {31'b0, s_req}, 32'd1);
    check("wl_addr", s_addr, 32'h20);
    check("wl_we", {31'b0, s_we}, 32'd0);
    check("wl_be", {28'b0, s_be}, 32'hF);
    check("wl_rdata", ReadDataO, 32'hDEADBEEF);
    check("wl_regwrite", {31'b0, RegWriteO}, 32'd1);
    check("wl_memtoreg", {31'b0, MemtoRegO}, 32'd1);
    check("wl_wa3", {28'b0, WA3O}, 32'd3);
    check("wl_req_drop", {31'b0, bus.mem_req}, 32'd0);
    go_idle();
    check("wl_idle_rdata", ReadDataO, 32'd0);
    check("wl_idle_stall", {31'b0, StallM}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 4'd0, 32'h23, 32'h000000AB);
    run_op(1, 32'h0, stalls, s_addr, s_be, s_wdata, s_we, s_req, s_bubble);
    check("bs_stalls", stalls, 32'd2);
    check("bs_we", {31'b0, s_we}, 32'd1);
    check("bs_be", {28'b0, s_be}, 32'h8);
    check("bs_wdata", s_wdata, 32'hABABABAB);
    check("bs_addr", s_addr, 32'h20);
    go_idle();
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 4'd7, 32'h21, 32'h0);
    run_op(1, 32'h11223344, stalls, s_addr, s_be, s_wdata, s_we, s_req, s_bubble);
    check("bl_stalls", stalls, 32'd2);
    check("bl_be", {28'b0, s_be}, 32'h2);
    check("bl_rdata", ReadDataO, 32'h00000033);
    go_idle();
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 4'd2, 32'h27, 32'h0);
    run_op(1, 32'hCAFEF00D, stalls, s_addr, s_be, s_wdata, s_we, s_req, s_bubble);
    check("mw_addr", s_addr, 32'h24);
    check("mw_be", {28'b0, s_be}, 32'hF);
    check("mw_rdata", ReadDataO, 32'hCAFEF00D);
    go_idle();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h55;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("stray_ack_req", {31'b0, bus.mem_req}, 32'd0);
    check("stray_ack_stall", {31'b0, StallM}, 32'd0);
    @(negedge clk);
    #1;
    check("stray_ack_rdata", ReadDataO, 32'd0);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 4'd4, 32'h40, 32'h0);
    @(negedge clk);
    #1;
    check("mid_req", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h99;
    @(negedge clk);
    #1;
    check("mid_req_drop", {31'b0, bus.mem_req}, 32'd0);
    check("mid_stall", {31'b0, StallM}, 32'd0);
    check("mid_regwrite", {31'b0, RegWriteO}, 32'd0);
    check("mid_rdata", ReadDataO, 32'd0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
    check("late_ack_stall", {31'b0, StallM}, 32'd0);
    check("late_ack_rdata", ReadDataO, 32'd0);
`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 4'd6, 32'h50, 32'h0);
    run_op(100, 32'h77777777, stalls, s_addr, s_be, s_wdata, s_we, s_req, s_bubble);
    check("to_stalls", stalls, 32'd17);
    check("to_rdata", ReadDataO, 32'd0);
    check("to_req", {31'b0, bus.mem_req}, 32'd0);
    check("to_err", {31'b0, mem_err}, 32'd1);
    go_idle();
    @(negedge clk);
    #1;
    check("to_err_sticky", {31'b0, mem_err}, 32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
